// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch FSM feeding a small FIFO
// of 32-bit instructions from a 64-bit instruction memory.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   start, entry_pc         begin fetching at entry_pc
//   mem_req, mem_addr       8-byte aligned read request
//   mem_ack                 request accepted
//   mem_rvalid, mem_rdata   read data (low word at addr)
//   ir, ir_pc, ir_valid     head of instruction buffer
//   ir_ready                decoder consumes head
//   redirect, redirect_pc   control-flow change
//   halt                    all-zero instruction consumed
module fetch_sequencer #(
    parameter int BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [63:0] entry_pc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic [31:0] ir,
    output logic [63:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        halt
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;
    // Highest occupancy that still leaves room for a full line.
    localparam logic [CW-1:0] ROOM_MARK = CW'(BUF_DEPTH - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_STALL,
        S_HALT
    } state_t;

    state_t        r_state;
    logic [63:0]   r_fetch_pc;
    logic          r_skip_low;
    logic          r_drop;
    logic          r_halt;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_buf_ir [BUF_DEPTH];
    logic [63:0]   r_buf_pc [BUF_DEPTH];

    logic          w_active;
    logic          w_redirect;
    logic          w_pop;
    logic          w_halt_pop;
    logic          w_push;
    logic [CW-1:0] w_npush;
    logic [CW-1:0] w_count_next;
    logic          w_room;
    logic [31:0]   w_head_ir;
    logic [63:0]   w_head_pc;
    logic [PW-1:0] w_wptr1;
    logic [63:0]   w_redir_line;
    logic [63:0]   w_entry_line;
    logic          w_unused;

    // Word-offset bits below bit 2 carry no information.
    assign w_unused = ^{entry_pc[1:0], redirect_pc[1:0]};

    assign w_active = (r_state == S_FETCH) ||
                      (r_state == S_WAIT)  ||
                      (r_state == S_STALL);

    assign w_redirect   = redirect && w_active;
    assign w_head_ir    = r_buf_ir[r_rptr];
    assign w_head_pc    = r_buf_pc[r_rptr];
    assign w_pop        = (r_count != '0) && ir_ready;
    // A redirect discards the popped word, so it cannot halt.
    assign w_halt_pop   = w_pop && (w_head_ir == 32'h0) && !w_redirect;
    assign w_push       = (r_state == S_WAIT) && mem_rvalid &&
                          !r_drop && !w_redirect;
    assign w_npush      = !w_push    ? '0 :
                          r_skip_low ? CW'(1) : CW'(2);
    assign w_count_next = r_count + w_npush -
                          {{(CW-1){1'b0}}, w_pop};
    assign w_room       = (w_count_next <= ROOM_MARK);
    assign w_wptr1      = r_wptr + PW'(1);
    assign w_redir_line = {redirect_pc[63:3], 3'b000};
    assign w_entry_line = {entry_pc[63:3], 3'b000};

    assign mem_req  = (r_state == S_FETCH);
    assign mem_addr = mem_req ? r_fetch_pc : '0;
    assign ir_valid = (r_count != '0);
    assign ir       = ir_valid ? w_head_ir : '0;
    assign ir_pc    = ir_valid ? w_head_pc : '0;
    assign halt     = r_halt;

    // Storage has no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            if (r_skip_low) begin
                r_buf_ir[r_wptr] <= mem_rdata[63:32];
                r_buf_pc[r_wptr] <= r_fetch_pc + 64'd4;
            end else begin
                r_buf_ir[r_wptr]  <= mem_rdata[31:0];
                r_buf_pc[r_wptr]  <= r_fetch_pc;
                r_buf_ir[w_wptr1] <= mem_rdata[63:32];
                r_buf_pc[w_wptr1] <= r_fetch_pc + 64'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_redirect || w_halt_pop) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + (r_skip_low ? PW'(1) : PW'(2));
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= '0;
            r_skip_low <= 1'b0;
            r_drop     <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_fetch_pc <= w_entry_line;
                        r_skip_low <= entry_pc[2];
                    end
                end
                S_FETCH: begin
                    if (w_halt_pop) begin
                        r_state <= S_HALT;
                        r_halt  <= 1'b1;
                    end else if (w_redirect) begin
                        r_fetch_pc <= w_redir_line;
                        r_skip_low <= redirect_pc[2];
                        if (mem_ack) begin
                            r_state <= S_WAIT;
                            r_drop  <= 1'b1;
                        end
                    end else if (mem_ack) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_halt_pop) begin
                        r_state <= S_HALT;
                        r_halt  <= 1'b1;
                        r_drop  <= 1'b0;
                    end else if (w_redirect) begin
                        r_fetch_pc <= w_redir_line;
                        r_skip_low <= redirect_pc[2];
                        // A response arriving now is the stale one.
                        if (mem_rvalid) begin
                            r_state <= S_FETCH;
                            r_drop  <= 1'b0;
                        end else begin
                            r_drop  <= 1'b1;
                        end
                    end else if (mem_rvalid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_FETCH;
                        end else begin
                            r_fetch_pc <= r_fetch_pc + 64'd8;
                            r_skip_low <= 1'b0;
                            r_state    <= w_room ? S_FETCH : S_STALL;
                        end
                    end
                end
                S_STALL: begin
                    if (w_halt_pop) begin
                        r_state <= S_HALT;
                        r_halt  <= 1'b1;
                    end else if (w_redirect) begin
                        r_fetch_pc <= w_redir_line;
                        r_skip_low <= redirect_pc[2];
                        r_state    <= S_FETCH;
                    end else if (w_room) begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random and directed stimulus against an
// expected instruction stream derived from memory contents.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] entry_pc = '0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic [31:0] ir;
    logic [63:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        halt;

    fetch_sequencer #(.BUF_DEPTH(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .entry_pc(entry_pc),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .ir(ir),
        .ir_pc(ir_pc),
        .ir_valid(ir_valid),
        .ir_ready(ir_ready),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .halt(halt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] w;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] acks[$];
    logic [63:0] exp_next = '0;
    int          total = 0;
    int          bad = 0;
    int          npop = 0;
    bit          pend = 0;
    int          pend_dly = 0;
    logic [63:0] pend_addr = '0;
    int          ack_pct = 100;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          zero_en = 0;
    logic [63:0] zero_addr = '0;
    bit          expect_halt = 0;

    // Memory contents: fixed words at 0x1000, optional zero word,
    // otherwise a nonzero hash of the address.
    function automatic logic [31:0] memword(input logic [63:0] a);
        logic [31:0] x;
        if (zero_en && a == zero_addr) return 32'h0;
        if (a == 64'h1000) return 32'h00000513;
        if (a == 64'h1004) return 32'h00500093;
        x = (a[31:0] ^ a[63:32]) * 32'h9E3779B1 + 32'h7F4A7C15;
        if (x == 32'h0) x = 32'h13;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic refill();
        exp_t e;
        while (sb.size() < 16) begin
            e.pc = exp_next;
            e.w  = memword(exp_next);
            sb.push_back(e);
            exp_next += 64'd4;
        end
    endtask

    // One clock: drop pulses, then act as instruction memory.
    task automatic step();
        @(posedge clk);
        #1;
        start      = 1'b0;
        redirect   = 1'b0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        if (pend) begin
            if (pend_dly == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = {memword(pend_addr + 64'd4),
                              memword(pend_addr)};
                pend = 0;
            end else begin
                pend_dly--;
            end
        end else if (mem_req && reset_n &&
                     ($urandom_range(99) < ack_pct)) begin
            mem_ack   = 1'b1;
            pend      = 1;
            pend_addr = mem_addr;
            pend_dly  = $urandom_range(lat_max, lat_min);
            acks.push_back(mem_addr);
        end
        refill();
    endtask

    task automatic do_start(input logic [63:0] pc);
        entry_pc = pc;
        start    = 1'b1;
        sb.delete();
        exp_next = pc;
        refill();
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        redirect_pc = pc;
        redirect    = 1'b1;
        sb.delete();
        exp_next = pc;
        refill();
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        pend     = 0;
        ir_ready = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        sb.delete();
        acks.delete();
    endtask

    task automatic wait_ack(input string name);
        int n0;
        n0 = acks.size();
        for (int i = 0; i < 40 && acks.size() == n0; i++) step();
        if (acks.size() == n0) begin
            total++;
            bad++;
            $display("FAIL %s: got no ack in 40 cycles want ack", name);
        end
    endtask

    // Monitor: every consumed instruction is compared with the
    // head of the expected stream.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expect_halt) begin
                chk("halt_set", halt, 1);
                chk("halt_irv", ir_valid, 0);
                expect_halt = 0;
            end else if (reset_n && ir_valid && ir_ready && !redirect) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got pc %h want none", ir_pc);
                end else begin
                    e = sb.pop_front();
                    chk("ir_pc", ir_pc, e.pc);
                    chk("ir", ir, e.w);
                    chk("halt_early", halt, 0);
                    npop++;
                    if (e.w == 32'h0) expect_halt = 1;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [63:0] pc;
        int          npop0;

        #2;
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ir", ir, 0);
        chk("rst_irpc", ir_pc, 0);
        chk("rst_irv", ir_valid, 0);
        chk("rst_halt", halt, 0);
        do_reset();

        // Aligned entry, immediate memory.
        ack_pct = 100;
        lat_min = 0;
        lat_max = 0;
        do_start(64'h1000);
        step();
        chk("t37_req", mem_req, 1);
        chk("t37_addr", mem_addr, 64'h1000);
        step();
        step();
        chk("t37_lat", ir_valid, 1);
        chk("t37_ir", ir, 32'h00000513);
        chk("t37_pc", ir_pc, 64'h1000);
        ir_ready = 1'b1;
        repeat (6) step();
        ir_ready = 1'b0;
        do_reset();

        // Entry in the upper half of a line.
        do_start(64'h1004);
        step();
        chk("t38_addr", mem_addr, 64'h1000);
        step();
        step();
        chk("t38_irv", ir_valid, 1);
        chk("t38_pc", ir_pc, 64'h1004);
        chk("t38_ir", ir, 32'h00500093);
        chk("t38_req", mem_req, 1);
        chk("t38_next", mem_addr, 64'h1008);
        ir_ready = 1'b1;
        repeat (4) step();
        ir_ready = 1'b0;
        do_reset();

        // Buffer fills and stalls until two slots free.
        do_start(64'h1000);
        repeat (5) step();
        chk("t39_stall_req", mem_req, 0);
        chk("t39_stall_irv", ir_valid, 1);
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        chk("t39_pop1_req", mem_req, 0);
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        chk("t39_pop2_req", mem_req, 1);
        chk("t39_pop2_addr", mem_addr, 64'h1010);
        do_reset();

        // Redirect while waiting for data.
        lat_min = 3;
        lat_max = 3;
        do_start(64'h1000);
        wait_ack("t40_ack1");
        wait_ack("t40_ack2");
        step();
        do_redirect(64'h2000);
        step();
        chk("t40_flush", ir_valid, 0);
        wait_ack("t40_ack3");
        if (acks.size() > 0) chk("t40_addr", acks[$], 64'h2000);
        ir_ready = 1'b1;
        repeat (12) step();
        ir_ready = 1'b0;
        do_reset();

        // Asynchronous reset while requesting.
        ack_pct = 0;
        do_start(64'h5000);
        step();
        step();
        chk("t42_req", mem_req, 1);
        chk("t42_addr", mem_addr, 64'h5000);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t42_req_rst", mem_req, 0);
        chk("t42_addr_rst", mem_addr, 0);
        do_reset();

        // Response arriving after reset is ignored.
        ack_pct = 100;
        do_start(64'h6000);
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (6) step();
        chk("t36_irv", ir_valid, 0);
        chk("t36_req", mem_req, 0);
        do_reset();

        // Random traffic with redirects, including address wrap.
        ack_pct = 70;
        lat_min = 0;
        lat_max = 3;
        pc = {$urandom, $urandom};
        do_start(pc & ~64'h3);
        step();
        do_redirect(64'hFFFF_FFFF_FFFF_FFF4);
        npop0 = npop;
        repeat (3000) begin
            step();
            ir_ready = ($urandom_range(99) < 60);
            if ($urandom_range(99) < 2) begin
                if ($urandom_range(3) == 0) begin
                    pc = 64'hFFFF_FFFF_FFFF_FFE0;
                    pc[4:2] = 3'($urandom_range(7));
                end else begin
                    pc = {$urandom, $urandom} & ~64'h3;
                end
                do_redirect(pc);
            end
        end
        ir_ready = 1'b0;
        chk("rand_progress", (npop - npop0) > 300, 1);
        do_reset();

        // Consuming an all-zero instruction halts fetch.
        zero_en   = 1;
        zero_addr = 64'h3008;
        ack_pct   = 100;
        lat_max   = 2;
        do_start(64'h3000);
        ir_ready = 1'b1;
        for (int i = 0; i < 100 && !halt; i++) step();
        chk("halt_seen", halt, 1);
        repeat (3) begin
            step();
            chk("halt_noreq", mem_req, 0);
            chk("halt_hold", halt, 1);
        end
        ir_ready = 1'b0;
        do_start(64'h7000);
        step();
        step();
        chk("halt_nostart", mem_req, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("halt_rst", halt, 0);
        chk("halt_rst_req", mem_req, 0);
        zero_en = 0;
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
